// File: rtl/button_pkg.sv
// button_pkg: shared states, default timing and channel indices for the button conditioner
package button_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_t;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY = 25000000;
  localparam int DEF_REPEAT_PERIOD = 10000000;
  localparam logic [3:0] DEF_REPEAT_MASK = 4'b0111;
  localparam int BTN_DIGIT0 = 0;
  localparam int BTN_DIGIT1 = 1;
  localparam int BTN_DIGIT2 = 2;
  localparam int BTN_CONFIRM = 3;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchronize, debounce and edge-detect one active-low button with optional auto-repeat
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press_pulse,
  output logic held
);
  localparam int W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] DB = W'(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] RD_LAST = W'(REPEAT_DELAY - 1);
  localparam logic [W-1:0] RP_LAST = W'(REPEAT_PERIOD - 1);
  btn_state_t state;
  logic [1:0] sync_q;
  logic [W-1:0] cnt;
  logic rep;
  logic sync;
  assign sync = sync_q[1];
  // rep selects period mode once the first repeat after the initial delay has fired
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync_q <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      rep <= 1'b0;
      press_pulse <= 1'b0;
      held <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_n};
      press_pulse <= 1'b0;
      case (state)
        IDLE:
          if (!sync) begin
            state <= PRESS_WAIT;
            cnt <= ONE;
          end
        PRESS_WAIT:
          if (sync) begin
            state <= IDLE;
            cnt <= '0;
          end else if (cnt == DB) begin
            state <= HELD;
            press_pulse <= 1'b1;
            held <= 1'b1;
            cnt <= '0;
            rep <= 1'b0;
          end else cnt <= cnt + ONE;
        HELD:
          if (sync) begin
            state <= RELEASE_WAIT;
            cnt <= ONE;
          end else if (REPEAT_EN) begin
            if (cnt == (rep ? RP_LAST : RD_LAST)) begin
              press_pulse <= 1'b1;
              cnt <= '0;
              rep <= 1'b1;
            end else cnt <= cnt + ONE;
          end
        RELEASE_WAIT:
          if (!sync) begin
            state <= HELD;
            cnt <= '0;
            rep <= 1'b0;
          end else if (cnt == DB) begin
            state <= IDLE;
            held <= 1'b0;
            cnt <= '0;
          end else cnt <= cnt + ONE;
      endcase
    end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: per-button debounce/auto-repeat channels plus an any-held summary
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BUTTONS = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter logic [N_BUTTONS-1:0] REPEAT_MASK = DEF_REPEAT_MASK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] btn_n,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] held,
  output logic                 any_held
);
  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .REPEAT_EN(REPEAT_MASK[i])
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .btn_n(btn_n[i]),
      .press_pulse(press_pulse[i]),
      .held(held[i])
    );
  end
  assign any_held = |held;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of press, bounce, repeat, reset and release-bounce behaviour
module tb_button_conditioner;
  import button_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] btn_n;
  logic [3:0] press_pulse;
  logic [3:0] held;
  logic any_held;
  int n_checks = 0;
  int n_fail = 0;
  int t_now;
  int pc[4];
  int first[4];
  int last[4];
  int hc[4];

  button_conditioner #(
    .N_BUTTONS(4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3),
    .REPEAT_MASK(4'b0111)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_n(btn_n),
    .press_pulse(press_pulse),
    .held(held),
    .any_held(any_held)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear();
    t_now = 0;
    for (int b = 0; b < 4; b++) begin
      pc[b] = 0;
      first[b] = -1;
      last[b] = -1;
      hc[b] = 0;
    end
  endtask

  // advance n edges, sampling 1 time unit after each edge
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      t_now++;
      for (int b = 0; b < 4; b++) begin
        if (press_pulse[b]) begin
          if (pc[b] == 0) first[b] = t_now;
          last[b] = t_now;
          pc[b]++;
        end
        if (held[b]) hc[b]++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    btn_n = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pulse", 32'(press_pulse), 0);
    check("reset_held", 32'(held), 0);
    check("reset_any", 32'(any_held), 0);
    rst = 1'b1;
    run(5);

    // clean press on digit 0
    clear();
    btn_n[BTN_DIGIT0] = 1'b0;
    run(6);
    check("clean_early", 32'(pc[0]), 0);
    run(1);
    check("clean_pulse", 32'(press_pulse), 32'h1);
    check("clean_held", 32'(held), 32'h1);
    run(1);
    check("clean_one_cycle", 32'(press_pulse), 0);
    btn_n[BTN_DIGIT0] = 1'b1;
    run(6);
    check("clean_held_before_fall", 32'(held[0]), 1);
    run(1);
    check("clean_held_fall", 32'(held[0]), 0);
    check("clean_pulse_count", 32'(pc[0]), 1);
    check("clean_other_bits", 32'(pc[1] + pc[2] + pc[3] + hc[1] + hc[2] + hc[3]), 0);
    check("clean_held_cycles", 32'(hc[0]), 8);
    run(5);

    // bounce on digit 1
    clear();
    btn_n[BTN_DIGIT1] = 1'b0;
    run(3);
    btn_n[BTN_DIGIT1] = 1'b1;
    run(1);
    btn_n[BTN_DIGIT1] = 1'b0;
    run(2);
    btn_n[BTN_DIGIT1] = 1'b1;
    run(10);
    check("bounce_pulses", 32'(pc[1]), 0);
    check("bounce_held", 32'(hc[1]), 0);

    // auto-repeat on digit 2
    clear();
    btn_n[BTN_DIGIT2] = 1'b0;
    run(7);
    check("rep_press", 32'(press_pulse), 32'h4);
    run(10);
    check("rep_first", 32'(press_pulse), 32'h4);
    check("rep_count17", 32'(pc[2]), 2);
    run(3);
    check("rep_second", 32'(press_pulse), 32'h4);
    run(10);
    btn_n[BTN_DIGIT2] = 1'b1;
    run(12);
    check("rep_total", 32'(pc[2]), 7);
    check("rep_last", 32'(last[2]), 32);
    check("rep_released", 32'(held), 0);

    // confirm held equally long never repeats
    clear();
    btn_n[BTN_CONFIRM] = 1'b0;
    run(30);
    btn_n[BTN_CONFIRM] = 1'b1;
    run(12);
    check("confirm_total", 32'(pc[3]), 1);
    check("confirm_first", 32'(first[3]), 7);

    // simultaneous presses
    clear();
    btn_n = 4'b0110;
    run(7);
    check("simul_pulse", 32'(press_pulse), 32'h9);
    check("simul_any", 32'(any_held), 1);
    btn_n = 4'b1111;
    run(12);
    check("simul_any_off", 32'(any_held), 0);

    // reset during PRESS_WAIT, button still held afterwards
    clear();
    btn_n[BTN_DIGIT0] = 1'b0;
    run(4);
    rst = 1'b0;
    #1;
    check("rst_pw_outputs", 32'({press_pulse, held, any_held}), 0);
    run(3);
    rst = 1'b1;
    clear();
    run(6);
    check("rst_pw_early", 32'(pc[0]), 0);
    run(1);
    check("rst_pw_pulse", 32'(press_pulse), 32'h1);
    btn_n[BTN_DIGIT0] = 1'b1;
    run(12);

    // reset during repeat
    clear();
    btn_n[BTN_DIGIT2] = 1'b0;
    run(20);
    check("rst_rep_pre", 32'(held[2]), 1);
    rst = 1'b0;
    #1;
    check("rst_rep_outputs", 32'({press_pulse, held, any_held}), 0);
    run(3);
    rst = 1'b1;
    clear();
    run(7);
    check("rst_rep_repress", 32'(first[2]), 7);
    btn_n[BTN_DIGIT2] = 1'b1;
    run(12);

    // release bounce restarts the repeat delay
    clear();
    btn_n[BTN_DIGIT0] = 1'b0;
    run(10);
    btn_n[BTN_DIGIT0] = 1'b1;
    run(2);
    btn_n[BTN_DIGIT0] = 1'b0;
    run(12);
    check("rb_no_pulse", 32'(pc[0]), 1);
    check("rb_held_steady", 32'(hc[0]), 18);
    run(1);
    check("rb_repeat", 32'(press_pulse), 32'h1);
    btn_n[BTN_DIGIT0] = 1'b1;
    run(12);
    check("rb_final_held", 32'(held), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
